keypad_encoder: RTL and testbench
=================================

# keypad_encoder

Scans a 4×4 active-low matrix keypad, debounces it, and delivers one 4-bit key code with a `valid` level to the processor's keyboard input (`data`/`valid`). It is the source side of that interface: the processor samples `data` and `valid` every clock with no acknowledge, so this block holds `valid` high for exactly one debounced press–release episode. It sits between the board keypad pins and the processor top level.

## Interface
- `SCAN_DIV`, default 4: clocks per column slot; must be ≥ 4 to cover synchronizer settling.
- `DEBOUNCE`, default 3: consecutive matching samples (one sample per slot tick) required to accept a press or a release; must be ≥ 1.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `clr`  in  1: reset, asynchronous, active-low.
- `row_in`  in  4: keypad rows, active-low (pulled up off-chip), asynchronous to `clk`.
- `col_out`  out  4: column drive, one-hot active-low.
- `data`  out  4: key code = 4·row + col, where row and col are bit indices 0–3.
- `valid`  out  1: high while a debounced key is held.

## Operation
- `row_in` passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- Slot counter runs 0..`SCAN_DIV`-1. `tick` is active in the cycle where the counter equals `SCAN_DIV`-1; all sampling happens on `tick`.
- Column index `c` advances 0→1→2→3→0 on `tick`, but only in SCAN. `col_out` = ~(1<<c).
- Candidate row = lowest index i with `rs[i]`=0. If several rows are low, the lowest wins.
- States:
  - **SCAN**:
    - On `tick`, if any row is low: latch `cand`={row, c}, set `cnt`=1, freeze `c`, go to DEB_PRESS. If `DEBOUNCE`=1, go straight to HELD instead.
    - Otherwise advance `c`.
  - **DEB_PRESS**:
    - On `tick`, if the candidate computed from `rs` equals `cand`, increment `cnt`. When `cnt` reaches `DEBOUNCE`: `data`←`cand`, `valid`←1, go to HELD.
    - On mismatch or no row low: go to SCAN and advance `c`. `valid` and `data` are unchanged.
  - **HELD**:
    - `c` stays frozen, so keys in other columns are ignored.
    - On `tick`, if `rs[cand.row]`=1: `cnt`=1, go to DEB_REL. If `DEBOUNCE`=1, apply the DEB_REL exit immediately.
  - **DEB_REL**:
    - On `tick`, if `rs[cand.row]`=1, increment `cnt`. At `DEBOUNCE`: `valid`←0, go to SCAN and advance `c`.
    - If the row is low again: go to HELD; `valid` stays 1.
- `data` changes only on entry to HELD and retains the last code after release.
- A new press is accepted only after a full debounced release.

## Timing
- Reset values:
  - `col_out`=4'b1110, `data`=0, `valid`=0.
  - State SCAN, `c`=0, slot counter=0, `cnt`=0.
  - Synchronizer flops reset to 4'b1111.
- After `clr` deasserts, the first `tick` occurs on the `SCAN_DIV`-th clock. `col_out` changes in the following cycle.
- Pin-to-`rs` delay is 2 clocks. A press is seen only if `rs` shows it on the `tick` of its column slot.
- Press latency: `valid` and `data` update on the `tick` edge of the `DEBOUNCE`-th matching sample. That is (`DEBOUNCE`-1)·`SCAN_DIV` clocks after the detection tick.
- Release latency: `valid` falls on the `tick` of the `DEBOUNCE`-th consecutive released sample.
- `valid` and `data` are registered with no glitches. `data` is stable whenever `valid`=1.
- `clr` asserted in any state returns all outputs to their reset values immediately (asynchronously). Any in-progress debounce is discarded.
- Counters are sized by `$clog2` of the parameters and never wrap past their limits.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE`=3.
- **Reset and scan:** hold `clr`=0, then release it with no key pressed → `col_out`=1110, `data`=0, `valid`=0. `col_out` reads 1101, 1011, 0111, 1110 at 4-clock intervals.
- **Clean press:** hold row 2 low while column 1 is driven → detection on the column-1 tick. `valid`=1 and `data`=9 exactly 8 clocks later. `col_out` stays 1101 while the key is held.
- **Bounce:** row 2 low for a single column-1 tick, then released before the next tick → return to SCAN, `col_out` advances to 1011, `valid` never asserts.
- **Release:** after the clean press, release the key → `valid` falls on the 3rd released tick (8 clocks after the first released tick). `data` holds 9 and scanning resumes at 1011. A release glitch lasting 1 tick keeps `valid`=1.
- **Multiple keys:** rows 1 and 3 low in column 0 → `data`=4. Pressing key (0,2) while HELD on (1,0) → no effect on `data` or `valid`.
- **Reset mid-hold:** assert `clr` while HELD → in the same cycle `valid`=0, `data`=0, `col_out`=1110. After `clr` is released with the key still held, the key is re-detected and re-debounced through the normal path.

Source files
------------

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, debounces press and release,
// and holds a 4-bit key code with valid high for one press-release episode.
module keypad_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] data,
  output logic       valid
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;
  state_t        state;
  logic [3:0]    sync1, rs, cand;
  logic [SW-1:0] slot;
  logic [CW-1:0] cnt;
  logic [1:0]    c, row;
  logic          tick, any_low, row_up;
  assign tick    = slot == SLOT_LAST;
  assign any_low = rs != 4'hF;
  assign row     = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
  assign row_up  = rs[cand[3:2]];
  assign col_out = ~(4'b0001 << c);
  // Column index freezes outside SCAN so only the candidate's column is observed.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= 4'hF;
      rs    <= 4'hF;
      slot  <= '0;
      c     <= '0;
      cand  <= '0;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
      state <= SCAN;
    end else begin
      sync1 <= row_in;
      rs    <= sync1;
      slot  <= tick ? '0 : slot + 1'b1;
      if (tick)
        case (state)
          SCAN:
            if (any_low) begin
              cand <= {row, c};
              cnt  <= CW'(1);
              if (DEBOUNCE == 1) begin
                data  <= {row, c};
                valid <= 1'b1;
                state <= HELD;
              end else state <= DEB_PRESS;
            end else c <= c + 2'd1;
          DEB_PRESS:
            if (any_low && {row, c} == cand) begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                data  <= cand;
                valid <= 1'b1;
                state <= HELD;
              end
            end else begin
              state <= SCAN;
              c     <= c + 2'd1;
            end
          HELD:
            if (row_up) begin
              cnt <= CW'(1);
              if (DEBOUNCE == 1) begin
                valid <= 1'b0;
                state <= SCAN;
                c     <= c + 2'd1;
              end else state <= DEB_REL;
            end
          DEB_REL:
            if (row_up) begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                valid <= 1'b0;
                state <= SCAN;
                c     <= c + 2'd1;
              end
            end else state <= HELD;
          default: state <= SCAN;
        endcase
    end
  end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad matrix model plus a key-level reference model of
// scan and debounce behaviour, checked slot by slot against the encoder.
module tb_keypad_encoder;
  localparam int SD = 4;
  localparam int DB = 3;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [3:0] row_in, col_out, data;
  logic valid;
  logic [15:0] pressed = '0;
  int errors = 0;
  int checks = 0;
  int mstate, mcol, mcnt;
  logic [3:0] mcand, mdata;
  logic mvalid;

  always #5 clk = ~clk;

  // A row reads low when any pressed key on it sits in a driven (low) column.
  always_comb begin
    row_in = 4'hF;
    for (int i = 0; i < 4; i++) row_in[i] = ~|(pressed[4*i +: 4] & ~col_out);
  end

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .clr(clr), .row_in(row_in),
    .col_out(col_out), .data(data), .valid(valid)
  );

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mstate = 0; mcol = 0; mcnt = 0; mcand = '0; mdata = '0; mvalid = 1'b0;
  endtask

  // 0 idle scanning, 1 confirming press, 2 key held, 3 confirming release
  task automatic model_tick();
    int s;
    s = -1;
    for (int i = 3; i >= 0; i--) if (pressed[4*i + mcol]) s = i;
    case (mstate)
      0: if (s >= 0) begin mcand = 4'(4*s + mcol); mcnt = 1; mstate = 1; end
         else mcol = (mcol + 1) % 4;
      1: if (s >= 0 && 4*s + mcol == int'(mcand)) begin
           mcnt++;
           if (mcnt == DB) begin mdata = mcand; mvalid = 1'b1; mstate = 2; end
         end else begin mstate = 0; mcol = (mcol + 1) % 4; end
      2: if (!pressed[mcand]) begin mcnt = 1; mstate = 3; end
      default: if (!pressed[mcand]) begin
           mcnt++;
           if (mcnt == DB) begin mvalid = 1'b0; mstate = 0; mcol = (mcol + 1) % 4; end
         end else mstate = 2;
    endcase
  endtask

  task automatic step();
    clocks(SD);
    model_tick();
  endtask

  task automatic do_reset();
    clr = 1'b0;
    model_reset();
    clocks(3);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_seq [3];
    exp_seq = '{4'b1011, 4'b0111, 4'b1110};
    pressed = '0;
    clr = 1'b0;
    model_reset();
    clocks(2);
    checks += 3;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col_out); end
    if (data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    @(negedge clk);
    clr = 1'b1;
    clocks(SD - 1);
    checks++;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL pre_tick_col: got %b want 1110", col_out); end
    clocks(1);
    model_tick();
    checks++;
    if (col_out !== 4'b1101) begin errors++; $display("FAIL first_tick_col: got %b want 1101", col_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks += 2;
      if (col_out !== exp_seq[k]) begin errors++; $display("FAIL scan_col%0d: got %b want %b", k, col_out, exp_seq[k]); end
      if (valid !== 1'b0) begin errors++; $display("FAIL scan_valid%0d: got %b want 0", k, valid); end
    end
  endtask

  task automatic test_press();
    pressed = '0;
    do_reset();
    pressed[9] = 1'b1;
    step();
    step();
    checks += 2;
    if (col_out !== 4'b1101) begin errors++; $display("FAIL press_detect_col: got %b want 1101", col_out); end
    if (valid !== 1'b0) begin errors++; $display("FAIL press_detect_valid: got %b want 0", valid); end
    clocks(SD + 3);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL press_early_valid: got %b want 0", valid); end
    clocks(1);
    model_tick();
    model_tick();
    checks += 2;
    if (valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", valid); end
    if (data !== 4'd9) begin errors++; $display("FAIL press_data: got %0d want 9", data); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks += 3;
      if (col_out !== 4'b1101) begin errors++; $display("FAIL hold_col%0d: got %b want 1101", k, col_out); end
      if (valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b want 1", k, valid); end
      if (data !== 4'd9) begin errors++; $display("FAIL hold_data%0d: got %0d want 9", k, data); end
    end
  endtask

  task automatic test_release();
    pressed[9] = 1'b0;
    step();
    step();
    checks += 2;
    if (valid !== 1'b1) begin errors++; $display("FAIL rel_mid_valid: got %b want 1", valid); end
    clocks(SD - 1);
    if (valid !== 1'b1) begin errors++; $display("FAIL rel_early_valid: got %b want 1", valid); end
    clocks(1);
    model_tick();
    checks += 3;
    if (valid !== 1'b0) begin errors++; $display("FAIL rel_valid: got %b want 0", valid); end
    if (data !== 4'd9) begin errors++; $display("FAIL rel_data: got %0d want 9", data); end
    if (col_out !== 4'b1011) begin errors++; $display("FAIL rel_col: got %b want 1011", col_out); end
    pressed = '0;
    do_reset();
    pressed[9] = 1'b1;
    repeat (4) step();
    pressed[9] = 1'b0;
    step();
    pressed[9] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks += 2;
      if (valid !== 1'b1) begin errors++; $display("FAIL glitch_valid%0d: got %b want 1", k, valid); end
      if (data !== 4'd9) begin errors++; $display("FAIL glitch_data%0d: got %0d want 9", k, data); end
    end
  endtask

  task automatic test_bounce();
    pressed = '0;
    do_reset();
    step();
    pressed[9] = 1'b1;
    step();
    pressed[9] = 1'b0;
    step();
    checks += 2;
    if (col_out !== 4'b1011) begin errors++; $display("FAIL bounce_col: got %b want 1011", col_out); end
    if (valid !== 1'b0) begin errors++; $display("FAIL bounce_valid: got %b want 0", valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL bounce_after%0d: got %b want 0", k, valid); end
    end
  endtask

  task automatic test_multi_key();
    pressed = '0;
    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    do_reset();
    repeat (3) step();
    checks += 2;
    if (valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b want 1", valid); end
    if (data !== 4'd4) begin errors++; $display("FAIL multi_data: got %0d want 4", data); end
    pressed[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks += 3;
      if (valid !== 1'b1) begin errors++; $display("FAIL other_col_valid%0d: got %b want 1", k, valid); end
      if (data !== 4'd4) begin errors++; $display("FAIL other_col_data%0d: got %0d want 4", k, data); end
      if (col_out !== 4'b1110) begin errors++; $display("FAIL other_col_col%0d: got %b want 1110", k, col_out); end
    end
  endtask

  task automatic test_reset_mid_hold();
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    checks += 3;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    if (data !== 4'd0) begin errors++; $display("FAIL mid_rst_data: got %0d want 0", data); end
    if (col_out !== 4'b1110) begin errors++; $display("FAIL mid_rst_col: got %b want 1110", col_out); end
    do_reset();
    step();
    step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL redetect_early: got %b want 0", valid); end
    step();
    checks += 2;
    if (valid !== 1'b1) begin errors++; $display("FAIL redetect_valid: got %b want 1", valid); end
    if (data !== 4'd4) begin errors++; $display("FAIL redetect_data: got %0d want 4", data); end
  endtask

  task automatic test_random();
    logic [15:0] one;
    one = 16'd1;
    pressed = '0;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 5) == 0)
        case ($urandom_range(0, 3))
          0: pressed = '0;
          3: pressed = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
          default: pressed = one << $urandom_range(0, 15);
        endcase
      clocks(2);
      checks += 2;
      if (valid !== mvalid) begin errors++; $display("FAIL rnd_mid_valid@%0d: got %b want %b", n, valid, mvalid); end
      if (data !== mdata) begin errors++; $display("FAIL rnd_mid_data@%0d: got %0d want %0d", n, data, mdata); end
      clocks(SD - 2);
      model_tick();
      checks += 3;
      if (col_out !== 4'(~(4'b0001 << mcol))) begin errors++; $display("FAIL rnd_col@%0d: got %b want %b", n, col_out, 4'(~(4'b0001 << mcol))); end
      if (valid !== mvalid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, valid, mvalid); end
      if (data !== mdata) begin errors++; $display("FAIL rnd_data@%0d: got %0d want %0d", n, data, mdata); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_multi_key();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
